// File: rtl/msdap_pkg.sv
// msdap_pkg: shared word width, word type and transmitter state encoding.
package msdap_pkg;
    localparam int MSDAP_WORD_W = 40;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef logic [MSDAP_WORD_W-1:0] msdap_word_t;
endpackage

// File: rtl/msdap_tx_shifter.sv
// msdap_tx_shifter: parallel-load, MSB-first shift register with load/shift enables.
module msdap_tx_shifter
    import msdap_pkg::*;
#(
    parameter int W = MSDAP_WORD_W
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] shift_q, shift_d;
    always_comb shift_d = load ? din : shift ? {shift_q[W-2:0], 1'b0} : shift_q;
    always_ff @(posedge clk) begin
        if (clear) shift_q <= '0;
        else       shift_q <= shift_d;
    end
    assign msb = shift_q[W-1];
endmodule

// File: rtl/msdap_serial_tx.sv
// msdap_serial_tx: stages one L/R result pair and shifts it out MSB-first per frame.
// Optional MSDAP_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module msdap_serial_tx
    import msdap_pkg::*;
#(
    parameter int WORD_W = MSDAP_WORD_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              bit_en,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] data_l,
    input  logic [WORD_W-1:0] data_r,
    output logic              out_l,
    output logic              out_r,
    output logic              out_ready,
    output logic              underrun,
    output logic              frame_err
`ifdef MSDAP_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);
    tx_state_t         state_q, state_d;
    logic              stage_full_q, stage_full_d;
    logic [WORD_W-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              underrun_q, underrun_d;
    logic              frame_err_q, frame_err_d;
    logic              load, shift, msb_l, msb_r;
    always_comb begin
        state_d      = state_q;
        stage_full_d = stage_full_q;
        stage_l_d    = stage_l_q;
        stage_r_d    = stage_r_q;
        bit_cnt_d    = bit_cnt_q;
        underrun_d   = 1'b0;
        frame_err_d  = frame_err_q;
        load         = 1'b0;
        shift        = 1'b0;
        if (in_valid && !stage_full_q) begin
            stage_full_d = 1'b1;
            stage_l_d    = data_l;
            stage_r_d    = data_r;
        end
        if (state_q == TX_IDLE) begin
            if (frame_start && stage_full_q) begin
                load         = 1'b1;
                stage_full_d = 1'b0;
                bit_cnt_d    = '0;
                state_d      = TX_SHIFT;
            end else if (frame_start) begin
                underrun_d = 1'b1;
            end
        end else begin
            // A frame strobe mid-word never reloads, even on the final bit.
            if (frame_start) frame_err_d = 1'b1;
            if (bit_en) begin
                if (bit_cnt_q == LAST) begin
                    state_d = TX_IDLE;
                end else begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= TX_IDLE;
            stage_full_q <= 1'b0;
            stage_l_q    <= '0;
            stage_r_q    <= '0;
            bit_cnt_q    <= '0;
            underrun_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_full_q <= stage_full_d;
            stage_l_q    <= stage_l_d;
            stage_r_q    <= stage_r_d;
            bit_cnt_q    <= bit_cnt_d;
            underrun_q   <= underrun_d;
            frame_err_q  <= frame_err_d;
        end
    end
    msdap_tx_shifter #(.W(WORD_W)) u_shift_l (
        .clk(clk), .clear(clear), .load(load), .shift(shift), .din(stage_l_q), .msb(msb_l)
    );
    msdap_tx_shifter #(.W(WORD_W)) u_shift_r (
        .clk(clk), .clear(clear), .load(load), .shift(shift), .din(stage_r_q), .msb(msb_r)
    );
    assign out_ready = (state_q == TX_SHIFT);
    assign out_l     = out_ready & msb_l;
    assign out_r     = out_ready & msb_r;
    assign in_ready  = !stage_full_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;
`ifdef MSDAP_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    always_comb ucnt_d = (underrun_q && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    always_ff @(posedge clk) begin
        if (clear) ucnt_q <= '0;
        else       ucnt_q <= ucnt_d;
    end
    assign underrun_cnt = ucnt_q;
`endif
endmodule
